harvard_test_sequencer: RTL
===========================

HARVARD_TEST_SEQUENCER -- requirements
Module: harvard_test_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of program-table entries; power of two, 2..256.
REQ-002 Parameter RST_CYCLES, default 1: cycles dut_reset is held high before the first entry is presented; range 1..15.
REQ-003 Parameter DATA_W, default 32: width of every instruction, data, address and expect field.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load_en, load_idx[$clog2(DEPTH)-1:0], load_instr, load_data, load_expect, load_kind[1:0]  in  table write port.
REQ-007 prog_len  in  $clog2(DEPTH)+1  number of entries to run, 1..DEPTH.
REQ-008 start  in  1  one-cycle pulse; begins a run.
REQ-009 dut_reset, clk_enable  out  1  drive the CPU's reset and clk_enable.
REQ-010 instr_readdata, data_readdata  out  DATA_W  stimulus to the CPU.
REQ-011 instr_address, data_address, register_v0  in  DATA_W  CPU observables.
REQ-012 active  in  1  CPU active flag.
REQ-013 busy, done, pass  out  1; fail_index  out  $clog2(DEPTH)  first failing entry.

Function
REQ-014 FSM states SHALL be IDLE, RST, RUN, DONE.
REQ-015 IDLE: load_en high SHALL write all fields into entry load_idx on the rising edge; load_en in any other state SHALL be ignored.
REQ-016 IDLE -> RST on start; IDLE SHALL also clear done, pass and fail_index, and take the start edge only if prog_len is in 1..DEPTH (otherwise stay IDLE).
REQ-017 RST: dut_reset=1 for exactly RST_CYCLES cycles, then -> RUN with idx=0.
REQ-018 RUN: instr_readdata and data_readdata SHALL combinationally equal entry[idx] fields; outside RUN both SHALL be 0.
REQ-019 RUN: at each rising edge entry[idx] is checked by kind: 0 none; 1 instr_address==expect; 2 register_v0==expect; 3 data_address==expect.
REQ-020 First mismatch SHALL latch fail_index=idx and a sticky fail flag; later mismatches SHALL NOT overwrite it.
REQ-021 idx SHALL increment by one per RUN cycle; at the edge where idx==prog_len-1 -> DONE, with no wrap to 0.
REQ-022 RUN: active falling to 0 SHALL end the run early (-> DONE) without recording a failure.
REQ-023 DONE: done=1, pass=!fail; hold until start (-> RST, fields cleared) or reset.
REQ-024 busy=1 in RST and RUN only; clk_enable=1 in RST and RUN, 0 otherwise.
REQ-025 start while busy SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, idx=0, dut_reset=1, clk_enable=0, busy=done=pass=0, fail_index=0.
REQ-027 dut_reset SHALL be high throughout IDLE.
REQ-028 Reset mid-run SHALL abort without raising done; table contents SHALL be preserved (no reset on table storage).

Structure
REQ-029 Package harvard_seq_pkg SHALL hold the state enum, the check-kind enum (NONE, IADDR, V0, DADDR) and the entry struct.
REQ-030 Table storage SHALL be a sub-module harvard_seq_table: 1 write port, 1 combinational read port, DEPTH entries.

Verification
REQ-031 Entries:
- 0: instr 0x8C0C0000, data 0xB000FFFF
- 1: instr 0x01800008
- 2: kind IADDR, expect 0xB000FFFF
- prog_len=3, start.
Required: done=1, pass=1.

REQ-032 Same program, entry 2 expect 0xB0010000 -> pass=0, fail_index=2.

REQ-033 Two mismatching entries, idx 1 and 3 -> fail_index=1.

REQ-034 load_en pulsed during RUN with load_idx=0, load_instr=0xFFFFFFFF -> the rerun presents the original entry 0.

REQ-035 reset asserted in RUN at idx=1 -> IDLE next cycle, done=0, dut_reset=1; a following start reruns with the table intact.

REQ-036 prog_len=DEPTH -> exactly DEPTH RUN cycles, then DONE; no wrap to 0.

Source files
------------

// File: rtl/harvard_seq_pkg.sv
// Shared types for the Harvard CPU test sequencer: sequencer states, the
// per-entry check kinds, the program-table entry layout and the entry check.
package harvard_seq_pkg;

  // Entry fields are stored at this width and zero-extended from the
  // sequencer's DATA_W, so one entry type serves every instance up to 64 bits.
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    IADDR = 2'd1,
    V0    = 2'd2,
    DADDR = 2'd3
  } check_kind_e;

  typedef struct packed {
    check_kind_e             kind;
    logic [MAX_DATA_W-1:0]   instr;
    logic [MAX_DATA_W-1:0]   data;
    logic [MAX_DATA_W-1:0]   expected;
  } seq_entry_t;

  // True when the CPU observable selected by the entry's kind differs from
  // the entry's expected value; entries of kind NONE never mismatch.
  function automatic logic entryMismatch(
    input seq_entry_t            e,
    input logic [MAX_DATA_W-1:0] iaddr,
    input logic [MAX_DATA_W-1:0] v0,
    input logic [MAX_DATA_W-1:0] daddr
  );
    logic m;
    m = 1'b0;
    case (e.kind)
      IADDR:   m = (iaddr != e.expected);
      V0:      m = (v0 != e.expected);
      DADDR:   m = (daddr != e.expected);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/harvard_seq_table.sv
// Program table: DEPTH entries with one synchronous write port and one
// combinational read port. Storage is deliberately not reset so a program
// survives a sequencer reset.
module harvard_seq_table
  import harvard_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     wrEn_i,
  input  logic [$clog2(DEPTH)-1:0] wrIdx_i,
  input  seq_entry_t               wrEntry_i,
  input  logic [$clog2(DEPTH)-1:0] rdIdx_i,
  output seq_entry_t               rdEntry_o
);

  seq_entry_t mem_q [DEPTH];

  // Write the whole entry on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrIdx_i] <= wrEntry_i;
    end
  end

  assign rdEntry_o = mem_q[rdIdx_i];

endmodule

// File: rtl/harvard_test_sequencer.sv
// Harvard CPU test sequencer: holds the CPU in reset, then presents one
// program-table entry per clock and checks a CPU observable against each
// entry's expected value, latching the first failing index.
module harvard_test_sequencer
  import harvard_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_instr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic [DATA_W-1:0]        load_expect,
  input  logic [1:0]               load_kind,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  output logic                     dut_reset,
  output logic                     clk_enable,
  output logic [DATA_W-1:0]        instr_readdata,
  output logic [DATA_W-1:0]        data_readdata,
  input  logic [DATA_W-1:0]        instr_address,
  input  logic [DATA_W-1:0]        data_address,
  input  logic [DATA_W-1:0]        register_v0,
  input  logic                     active,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH)-1:0] fail_index
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned LW = IW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [3:0]    RST_LAST = 4'(RST_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]    rstCnt_q, rstCnt_d;
  logic          fail_q, fail_d;
  logic [IW-1:0] failIdx_q, failIdx_d;
  logic          activePrev_q;

  seq_entry_t wrEntry;
  seq_entry_t rdEntry;
  logic       tableWrEn;
  logic       mismatch;
  logic       lenValid;
  logic       lastIdx;
  logic       activeFell;
  logic       unusedBits;

  // The table only accepts writes while idle so a running program is stable.
  assign tableWrEn        = load_en && (state_q == IDLE);
  assign wrEntry.kind     = check_kind_e'(load_kind);
  assign wrEntry.instr    = MAX_DATA_W'(load_instr);
  assign wrEntry.data     = MAX_DATA_W'(load_data);
  assign wrEntry.expected = MAX_DATA_W'(load_expect);

  harvard_seq_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i     (clk),
    .wrEn_i    (tableWrEn),
    .wrIdx_i   (load_idx),
    .wrEntry_i (wrEntry),
    .rdIdx_i   (idx_q),
    .rdEntry_o (rdEntry)
  );

  assign mismatch   = entryMismatch(rdEntry,
                                    MAX_DATA_W'(instr_address),
                                    MAX_DATA_W'(register_v0),
                                    MAX_DATA_W'(data_address));
  assign lenValid   = (prog_len != '0) && (prog_len <= DEPTH_L);
  assign lastIdx    = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign activeFell = activePrev_q && !active;

  // Next-state logic: reset hold, one entry per RUN cycle, first-failure latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    rstCnt_d  = rstCnt_q;
    fail_d    = fail_q;
    failIdx_d = failIdx_q;
    case (state_q)
      IDLE: begin
        fail_d    = 1'b0;
        failIdx_d = '0;
        if (start && lenValid) begin
          state_d  = RST;
          rstCnt_d = '0;
          len_d    = prog_len;
          idx_d    = '0;
        end
      end
      RST: begin
        if (rstCnt_q == RST_LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          rstCnt_d = rstCnt_q + 4'd1;
        end
      end
      RUN: begin
        if (activeFell) begin
          state_d = DONE;
        end else begin
          if (mismatch && !fail_q) begin
            fail_d    = 1'b1;
            failIdx_d = idx_q;
          end
          if (lastIdx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (start && lenValid) begin
          state_d   = RST;
          rstCnt_d  = '0;
          len_d     = prog_len;
          idx_d     = '0;
          fail_d    = 1'b0;
          failIdx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any run but leaves the table untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      rstCnt_q     <= '0;
      fail_q       <= 1'b0;
      failIdx_q    <= '0;
      activePrev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      rstCnt_q     <= rstCnt_d;
      fail_q       <= fail_d;
      failIdx_q    <= failIdx_d;
      activePrev_q <= active;
    end
  end

  assign dut_reset      = (state_q == IDLE) || (state_q == RST);
  assign busy           = (state_q == RST) || (state_q == RUN);
  assign clk_enable     = busy;
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && !fail_q;
  assign fail_index     = failIdx_q;
  assign instr_readdata = (state_q == RUN) ? rdEntry.instr[DATA_W-1:0] : '0;
  assign data_readdata  = (state_q == RUN) ? rdEntry.data[DATA_W-1:0]  : '0;

  // Upper bits of the zero-extended stimulus fields are never presented.
  assign unusedBits = ^{rdEntry.instr, rdEntry.data};

endmodule
